// File: rtl/bcla16_seq_add.sv
// bcla16_seq_add: multi-cycle WORDS*16-bit adder built around one 16-bit
// block-carry-lookahead slice. Operands arrive over a valid/ready handshake and
// are summed one 16-bit chunk per clock, least significant chunk first. The
// inter-chunk carry is rebuilt from the slice's group generate/propagate.
// Optional feature macro: BCLA_SEQ_SUB_EN (adds a `sub` port for A-B).
module bcla16_seq_add #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  input  logic                  cin,
`ifdef BCLA_SEQ_SUB_EN
  input  logic                  sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   sum,
  output logic                  cout,
  output logic                  ovf
);

  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // One 16-bit slice: four 4-bit lookahead groups joined by a second lookahead
  // level. Returns {group_g, group_p, sum[15:0]}.
  function automatic logic [17:0] bcla16(input logic [15:0] x, input logic [15:0] y,
                                         input logic ci);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  pp;
    logic [3:0]  gc;
    logic        grp_g;
    logic        grp_p;
    g = x & y;
    p = x ^ y;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pp[k] = &p[4*k +: 4];
    end
    gc[0] = ci;
    gc[1] = gg[0] | (pp[0] & ci);
    gc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
    gc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & ci);
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int j = 1; j < 4; j++) begin
        c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
      end
    end
    grp_g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0]);
    grp_p = &pp;
    return {grp_g, grp_p, p ^ c};
  endfunction

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          c;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [15:0]   a_words [WORDS];
  logic [15:0]   b_words [WORDS];
  logic [17:0]   slice_s;
  logic          c_next;
  logic [W-1:0]  b_eff_in;
  logic          cin_eff_in;

`ifdef BCLA_SEQ_SUB_EN
  assign b_eff_in   = sub ? ~b : b;
  assign cin_eff_in = sub ? 1'b1 : cin;
`else
  assign b_eff_in   = b;
  assign cin_eff_in = cin;
`endif

  for (genvar i = 0; i < WORDS; i++) begin : g_words
    assign a_words[i] = a_r[16*i +: 16];
    assign b_words[i] = b_r[16*i +: 16];
  end

  // Current chunk through the slice and the carry into the next chunk.
  always_comb begin
    slice_s = bcla16(a_words[idx], b_words[idx], c);
    c_next  = slice_s[17] | (slice_s[16] & c);
  end

  assign in_ready  = (state == IDLE) & ~rst;
  assign out_valid = (state == DONE);

  // Handshake FSM, operand capture and chunk-by-chunk result build-up.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      c     <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b_eff_in;
            c     <= cin_eff_in;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < WORDS; i++) begin
            if (idx == IW'(i)) begin
              sum[16*i +: 16] <= slice_s[15:0];
            end
          end
          c <= c_next;
          if (idx == LAST) begin
            idx   <= '0;
            state <= DONE;
            cout  <= c_next;
            ovf   <= (a_r[W-1] == b_r[W-1]) & (slice_s[15] != a_r[W-1]);
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
